// File: rtl/arbitro_escrita_banco.sv
// Write-port arbiter for the MIPS register file: requester 0 has fixed priority, the others
// share the port round-robin with starvation preemption; the winning write is registered.
module arbitro_escrita_banco #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                     ck,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic                     WE3,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     zero_drop
);
    localparam int unsigned ID_W       = $clog2(N_REQ);
    localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0]        wait_cnt [1:N_REQ-1];
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   scan_idx [N_REQ-1];
    logic              sel_any;
    logic [ID_W-1:0]   sel_id;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Scan order over requesters 1..N_REQ-1, starting at rr_ptr and wrapping back to 1.
    always_comb begin
        for (int unsigned k = 0; k < N_REQ - 1; k++) begin
            int unsigned pos;
            pos = 32'(rr_ptr) + k;
            if (pos >= N_REQ) pos = pos - (N_REQ - 1);
            scan_idx[k] = ID_W'(pos);
        end
    end

    always_comb begin
        sel_any = 1'b0;
        sel_id  = '0;
        for (int unsigned k = 0; k < N_REQ - 1; k++) begin
            if (!sel_any && req_valid[scan_idx[k]] && wait_cnt[scan_idx[k]] == STARVE_LIM) begin
                sel_any = 1'b1;
                sel_id  = scan_idx[k];
            end
        end
        if (!sel_any && req_valid[0]) begin
            sel_any = 1'b1;
            sel_id  = '0;
        end
        for (int unsigned k = 0; k < N_REQ - 1; k++) begin
            if (!sel_any && req_valid[scan_idx[k]]) begin
                sel_any = 1'b1;
                sel_id  = scan_idx[k];
            end
        end
    end

    assign sel_addr = req_addr[sel_id*ADDR_W +: ADDR_W];
    assign sel_data = req_data[sel_id*DATA_W +: DATA_W];

    always_comb begin
        req_ready = '0;
        if (reset_n && sel_any) req_ready[sel_id] = 1'b1;
    end

    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < N_REQ; i++) wait_cnt[i] <= '0;
            rr_ptr    <= ID_W'(1);
            WE3       <= 1'b0;
            A3        <= '0;
            WD3       <= '0;
            grant_id  <= '0;
            zero_drop <= 1'b0;
        end else begin
            for (int i = 1; i < N_REQ; i++) begin
                if (!req_valid[i] || (sel_any && sel_id == ID_W'(i))) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != STARVE_LIM) begin
                    wait_cnt[i] <= wait_cnt[i] + 8'd1;
                end
            end
            if (sel_any) begin
                grant_id <= sel_id;
                if (sel_id != '0) begin
                    rr_ptr <= (sel_id == ID_W'(N_REQ - 1)) ? ID_W'(1) : sel_id + ID_W'(1);
                end
                // Register 0 is hardwired: acknowledge the request but suppress the write.
                if (sel_addr != '0) begin
                    WE3       <= 1'b1;
                    A3        <= sel_addr;
                    WD3       <= sel_data;
                    zero_drop <= 1'b0;
                end else begin
                    WE3       <= 1'b0;
                    zero_drop <= 1'b1;
                end
            end else begin
                WE3       <= 1'b0;
                zero_drop <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Bench for arbitro_escrita_banco: directed scenarios plus randomized traffic checked
// against a behavioural arbitration model.
module tb_arbitro_escrita_banco;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SM = 3;

    logic          ck      = 1'b0;
    logic          reset_n = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ready;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic          WE3;
    logic [1:0]    grant_id;
    logic          zero_drop;

    int errors = 0;
    int checks = 0;

    int            m_wait [N];
    int            m_rr;
    logic          m_we;
    logic          m_zd;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd3;
    int            m_gid;

    logic [DW-1:0] rf [32];

    arbitro_escrita_banco #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)
    ) dut (
        .ck(ck), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .A3(A3), .WD3(WD3), .WE3(WE3),
        .grant_id(grant_id), .zero_drop(zero_drop)
    );

    always #5 ck = ~ck;

    // Register file stand-in: register 0 is never written.
    always @(posedge ck) if (WE3 && A3 != 0) rf[A3] <= WD3;

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]       = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        repeat (2) @(negedge ck);
        reset_n = 1'b1;
        m_rr = 1;
        foreach (m_wait[i]) m_wait[i] = 0;
        m_we = 0; m_zd = 0; m_a3 = '0; m_wd3 = '0; m_gid = 0;
    endtask

    // Arbitration rules stated directly: starving first (round-robin order), then 0, then RR.
    function automatic int model_pick(input logic [N-1:0] v);
        int order [N-1];
        int pick;
        pick = -1;
        for (int k = 0; k < N - 1; k++) order[k] = ((m_rr - 1 + k) % (N - 1)) + 1;
        for (int k = 0; k < N - 1; k++)
            if (pick < 0 && v[order[k]] && m_wait[order[k]] == SM) pick = order[k];
        if (pick < 0 && v[0]) pick = 0;
        for (int k = 0; k < N - 1; k++)
            if (pick < 0 && v[order[k]]) pick = order[k];
        return pick;
    endfunction

    task automatic model_update(input int g);
        logic [AW-1:0] a;
        for (int i = 1; i < N; i++) begin
            if (!req_valid[i] || g == i) m_wait[i] = 0;
            else m_wait[i] = (m_wait[i] < SM) ? m_wait[i] + 1 : SM;
        end
        if (g >= 0) begin
            m_gid = g;
            if (g > 0) m_rr = g % (N - 1) + 1;
            a = req_addr[g*AW +: AW];
            if (a != 0) begin
                m_we = 1; m_zd = 0; m_a3 = a; m_wd3 = req_data[g*DW +: DW];
            end else begin
                m_we = 0; m_zd = 1;
            end
        end else begin
            m_we = 0; m_zd = 0;
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'h100 + i));
        #2;
        checks++; if (req_ready !== 4'b0000) begin errors++;
            $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (WE3 !== 1'b0) begin errors++;
            $display("FAIL reset_we3: got %b want 0", WE3); end
        checks++; if (A3 !== 5'd0) begin errors++;
            $display("FAIL reset_a3: got %0d want 0", A3); end
        checks++; if (WD3 !== 32'd0) begin errors++;
            $display("FAIL reset_wd3: got %h want 0", WD3); end
        checks++; if (grant_id !== 2'd0 || zero_drop !== 1'b0) begin errors++;
            $display("FAIL reset_gid_zd: got %0d/%b want 0/0", grant_id, zero_drop); end
        repeat (2) @(negedge ck);
        reset_n   = 1'b1;
        req_valid = '0;
        set_req(2, 1'b1, 5'd5, 32'hCAFE0001);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++;
            $display("FAIL release_ready: got %b want 0100", req_ready); end
        @(posedge ck); #1;
        req_valid[2] = 1'b0;
        checks++; if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hCAFE0001) begin errors++;
            $display("FAIL release_write: got we=%b a=%0d d=%h want 1/5/cafe0001", WE3, A3, WD3); end
        checks++; if (grant_id !== 2'd2) begin errors++;
            $display("FAIL release_gid: got %0d want 2", grant_id); end
        @(posedge ck); #1;
        checks++; if (rf[5] !== 32'hCAFE0001) begin errors++;
            $display("FAIL release_rf: got %h want cafe0001", rf[5]); end
        checks++; if (WE3 !== 1'b0) begin errors++;
            $display("FAIL release_idle_we3: got %b want 0", WE3); end
    endtask

    task automatic test_priority();
        int order [4] = '{0, 1, 2, 3};
        apply_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(8 + i), DW'(32'h200 + i));
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << order[k])) begin errors++;
                $display("FAIL prio_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << order[k])); end
            @(posedge ck); #1;
            req_valid[order[k]] = 1'b0;
            checks++; if (WE3 !== 1'b1 || grant_id !== 2'(order[k]) || A3 !== AW'(8 + order[k]))
                begin errors++;
                $display("FAIL prio_write[%0d]: got we=%b id=%0d a=%0d want 1/%0d/%0d",
                         k, WE3, grant_id, A3, order[k], 8 + order[k]); end
        end
        // Pointer must be back at 1: requester 1 beats 2.
        set_req(2, 1'b1, 5'd3, 32'h3);
        set_req(1, 1'b1, 5'd4, 32'h4);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++;
            $display("FAIL prio_rr_wrap: got %b want 0010", req_ready); end
    endtask

    task automatic test_starvation();
        int order [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        apply_reset();
        set_req(0, 1'b1, 5'd10, 32'h0);
        set_req(1, 1'b1, 5'd11, 32'h1000);
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << order[k])) begin errors++;
                $display("FAIL starve_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << order[k])); end
            @(posedge ck); #1;
            checks++; if (grant_id !== 2'(order[k]) || WE3 !== 1'b1) begin errors++;
                $display("FAIL starve_gid[%0d]: got %0d we=%b want %0d", k, grant_id, WE3, order[k]); end
            set_req(order[k], 1'b1, AW'(10 + order[k]), DW'(k + 1));
        end
    endtask

    task automatic test_zero_drop();
        apply_reset();
        set_req(3, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++;
            $display("FAIL zero_ready: got %b want 1000", req_ready); end
        @(posedge ck); #1;
        req_valid = '0;
        checks++; if (WE3 !== 1'b0 || zero_drop !== 1'b1 || grant_id !== 2'd3) begin errors++;
            $display("FAIL zero_drop: got we=%b zd=%b id=%0d want 0/1/3", WE3, zero_drop, grant_id); end
        @(posedge ck); #1;
        checks++; if (zero_drop !== 1'b0 || grant_id !== 2'd3) begin errors++;
            $display("FAIL zero_after: got zd=%b id=%0d want 0/3", zero_drop, grant_id); end
    endtask

    task automatic test_round_robin();
        int order [6] = '{1, 2, 3, 1, 2, 3};
        apply_reset();
        for (int i = 1; i < N; i++) set_req(i, 1'b1, AW'(16 + i), DW'(i));
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << order[k])) begin errors++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << order[k])); end
            @(posedge ck); #1;
            set_req(order[k], 1'b1, AW'(16 + order[k]), DW'(32'h50 + k));
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        set_req(1, 1'b1, 5'd4, 32'hA1);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++;
            $display("FAIL mid_first: got %b want 0010", req_ready); end
        @(posedge ck); #1;
        set_req(1, 1'b1, 5'd6, 32'hA2);
        set_req(2, 1'b1, 5'd7, 32'hB2);
        #1;
        checks++; if (req_ready !== 4'b0100 || WE3 !== 1'b1) begin errors++;
            $display("FAIL mid_before: got rdy=%b we=%b want 0100/1", req_ready, WE3); end
        reset_n = 1'b0;
        #1;
        checks++; if (WE3 !== 1'b0 || req_ready !== 4'b0000 || grant_id !== 2'd0) begin errors++;
            $display("FAIL mid_async: got we=%b rdy=%b id=%0d want 0/0000/0", WE3, req_ready, grant_id); end
        repeat (2) @(negedge ck);
        reset_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++;
            $display("FAIL mid_regrant: got %b want 0010", req_ready); end
        @(posedge ck); #1;
        checks++; if (grant_id !== 2'd1 || A3 !== 5'd6 || WE3 !== 1'b1) begin errors++;
            $display("FAIL mid_write: got id=%0d a=%0d we=%b want 1/6/1", grant_id, A3, WE3); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int g;
            logic [N-1:0] exp_rdy;
            #1;
            g = model_pick(req_valid);
            exp_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
            checks++; if (req_ready !== exp_rdy) begin errors++;
                $display("FAIL rand_ready@%0d: got %b want %b", cyc, req_ready, exp_rdy); end
            checks++; if (WE3 !== m_we || zero_drop !== m_zd || grant_id !== 2'(m_gid)
                          || A3 !== m_a3 || WD3 !== m_wd3) begin errors++;
                $display("FAIL rand_regs@%0d: got we=%b zd=%b id=%0d a=%0d d=%h want %b/%b/%0d/%0d/%h",
                         cyc, WE3, zero_drop, grant_id, A3, WD3, m_we, m_zd, m_gid, m_a3, m_wd3); end
            @(posedge ck);
            model_update(g);
            #1;
            if (g >= 0) req_valid[g] = 1'b0;
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 99) < 45)
                    set_req(i, 1'b1, AW'($urandom_range(0, 31)), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_starvation();
        test_zero_drop();
        test_round_robin();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arbitro_escrita_banco.md
# arbitro_escrita_banco

Write-port arbiter for the MIPS register file (`bancoRegistradores`). It shares the single write port (A3/WD3/WE3) among N requesters, such as pipeline writeback, the load unit and debug/init. Each requester uses a valid/ready handshake. Selection is fixed-priority for requester 0, with round-robin and starvation protection for the others. The winning write is registered and drives the register file one cycle after the handshake.

## Interface
- N_REQ, 4: number of requesters (2..8); requester 0 is the priority port.
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- STARVE_MAX, 8: cycles a waiting requester i≥1 may be passed over before it preempts requester 0 (1..255).

Ports:
- ck  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  bit i: requester i has a write pending.
- req_addr  in  N_REQ*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot or zero, combinational; a transfer occurs when req_valid[i] & req_ready[i].
- A3  out  ADDR_W  registered write address to the register file.
- WD3  out  DATA_W  registered write data.
- WE3  out  1  registered write enable.
- grant_id  out  $clog2(N_REQ)  registered index of the last granted requester.
- zero_drop  out  1  registered pulse: the last grant targeted register 0 and was discarded.

## Operation
- **Handshake.**
  - Once req_valid[i] is raised, it stays high with addr/data stable until the cycle req_ready[i]=1.
  - req_ready[i] is never 1 while req_valid[i]=0.
  - At most one grant per cycle.
- **Starvation counters.** wait_cnt[i], 8-bit, exists for i≥1 only.
  - On each rising edge: cleared if req_valid[i]=0 or requester i is granted.
  - Otherwise incremented, saturating at STARVE_MAX.
- **Selection, per cycle, first match wins:**
  - Any i≥1 with wait_cnt[i]==STARVE_MAX: grant the first such i, scanning from rr_ptr upward and wrapping N_REQ-1 → 1.
  - Else, if req_valid[0]: grant 0.
  - Else: grant the first valid i≥1, scanning from rr_ptr with the same wrap.
  - Else: no grant.
- **Round-robin pointer.**
  - rr_ptr ranges over 1..N_REQ-1; reset value 1.
  - After a grant to i≥1: rr_ptr ← i+1, wrapping to 1.
  - A grant to 0 leaves rr_ptr unchanged.
- **Output register, on each rising edge:**
  - Grant with addr≠0: WE3←1, A3←addr, WD3←data, grant_id←i, zero_drop←0.
  - Grant with addr==0: request completes (ready=1), WE3←0, zero_drop←1, grant_id←i. The grant still counts for rr_ptr and wait_cnt.
  - No grant: WE3←0, zero_drop←0; A3, WD3 and grant_id hold.
- **Same-cycle contention.** Requests to the same register from different requesters are serialized in grant order and never merged; the last writer wins in the register file.
- **Reset values.**
  - WE3=0, A3=0, WD3=0, grant_id=0, zero_drop=0, all wait_cnt=0, rr_ptr=1.
  - req_ready is forced to 0 while reset_n=0.
- **Reset mid-operation.** Pending requests are not retained. Requesters must re-present them; a request not yet acknowledged is simply re-arbitrated after reset.

## Timing
- Handshake at cycle t (combinational ready) → WE3/A3/WD3 valid during cycle t+1 → register file stores the data at the edge ending t+1 → RD1/RD2 reflect it from t+2.
- Back-to-back grants give one write per cycle; WE3 can stay high continuously.
- Latency of requester 0 under load: ≤1 cycle unless a starvation preemption occurs.
- Worst-case wait of a requester i≥1 with requester 0 saturating the port: STARVE_MAX cycles, plus up to N_REQ-2 further cycles behind other starving requesters.
- reset_n deassertion is synchronized externally to ck; the first grant is possible in the first cycle after release.

## Test plan
- **Reset values.** reset_n=0 with all req_valid=1 → req_ready=0, WE3=0, A3=0, WD3=0. Release reset with only req_valid[2]=1, addr=5, data=0xCAFE0001 → ready[2] in the same cycle; next cycle WE3=1, A3=5, WD3=0xCAFE0001, grant_id=2; register file RD1 at A1=5 reads 0xCAFE0001 one cycle later.
- **Priority.** req_valid=4'b1111 for one cycle, each with a distinct addr → requester 0 granted first. Then 1, 2, 3 in successive cycles, rr_ptr ending at 1; WE3 high for 4 consecutive cycles.
- **Starvation preemption.** STARVE_MAX=3. Requester 0 continuously valid, requester 1 valid → grants 0, 0, 0, then requester 1 on the 4th cycle; wait_cnt[1] clears; requester 0 is granted again the next cycle.
- **Register-zero drop.** Requester 3 with addr=0, data=0xFFFFFFFF → ready[3]=1; next cycle WE3=0, zero_drop=1, grant_id=3; register 0 still reads 0.
- **Round-robin fairness.** Requesters 1..3 continuously valid, requester 0 idle → grant order 1, 2, 3, 1, 2, 3; no requester waits more than 2 cycles.
- **Reset mid-burst.** Requesters 1 and 2 pending; assert reset_n=0 during the cycle of requester 1's grant → WE3=0 asynchronously and rr_ptr=1. After release, with both still valid, requester 1 is granted again first.
